melody_player: RTL and testbench
================================

MELODY_PLAYER -- requirements
Module: melody_player

Interface
REQ-001 Parameter DEPTH, 128: note memory entries; AW = clog2(DEPTH).
REQ-002 Parameter HALF_W, 20: half-period field width in clk cycles.
REQ-003 Parameter DUR_W, 8: duration field width in ticks.
REQ-004 Parameter TICK_CYC, 500000: clk cycles per duration tick.
REQ-005 Parameter GAP_CYC, 2000000: silent articulation gap after every note, in clk cycles.
REQ-006 clk  in  1  single system clock; all logic on its rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 wr_en  in  1  note memory write strobe.
REQ-009 wr_addr  in  AW  note memory write address.
REQ-010 wr_data  in  HALF_W+DUR_W  {half_period, dur}; half_period = 0 means rest.
REQ-011 len  in  AW+1  number of notes to play (1..DEPTH), sampled at start acceptance.
REQ-012 start  in  1  play request, level-sampled.
REQ-013 stop  in  1  abort request, level-sampled.
REQ-014 loop  in  1  1 = repeat the sequence, sampled at each sequence end.
REQ-015 buzzer_pin  out  1  square-wave output.
REQ-016 busy  out  1  high from start acceptance until return to IDLE.
REQ-017 done  out  1  one-cycle pulse on normal (non-stop) completion.
REQ-018 note_idx  out  AW  index of the current note.

Function
REQ-019 Memory SHALL be DEPTH x (HALF_W+DUR_W), written synchronously when wr_en=1 regardless of state, read synchronously with 1-cycle latency.
REQ-020 FSM states SHALL be IDLE, LOAD, TONE, GAP.
REQ-021 IDLE: start=1, stop=0, len!=0 -> LOAD, latch len, note_idx=0, busy=1 after the same edge.
REQ-022 IDLE: start with len=0, or with stop=1, SHALL be ignored; start while busy SHALL be ignored.
REQ-023 LOAD SHALL last exactly 1 cycle, capture the memory word at note_idx, clear both counters, then -> TONE.
REQ-024 TONE SHALL last max(dur,1)*TICK_CYC cycles; dur=0 SHALL be treated as 1.
REQ-025 In TONE with half_period H!=0, buzzer_pin SHALL toggle when the half counter reaches H-1, then the counter clears; first toggle H cycles after TONE entry, giving period 2H.
REQ-026 In TONE with H=0, and in GAP, LOAD, IDLE, buzzer_pin SHALL be 0.
REQ-027 TONE end -> GAP; buzzer_pin is forced to 0 on the transition edge.
REQ-028 GAP SHALL last GAP_CYC cycles (0 = single cycle), then note_idx+1.
REQ-029 At GAP end with note_idx = len-1: loop=1 -> note_idx=0, LOAD; loop=0 -> IDLE, busy=0, done=1 for one cycle.
REQ-030 stop=1 in LOAD/TONE/GAP SHALL give IDLE on the next edge: buzzer_pin=0, busy=0, note_idx=0, no done.
REQ-031 Writes to an entry not yet loaded in the current pass SHALL take effect when that entry is loaded.
REQ-032 Duration counter width SHALL hold DUR_W-max * TICK_CYC without wrap.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, buzzer_pin=0, busy=0, done=0, note_idx=0 and clear all counters; memory contents are not reset.
REQ-034 Reset mid-play SHALL abort without a done pulse; the first rising clk edge after rst_n rises SHALL see IDLE.

Verification (TICK_CYC=4, GAP_CYC=2, DEPTH=8)
REQ-035 Memory[0]={3,2}, len=1, start pulse -> busy 1; pin toggles 3, 6 cycles after TONE entry; TONE 8 cycles; GAP 2; done pulse; busy 0.
REQ-036 Three notes with the middle one a rest ({0,1}), loop=0 -> pin 0 throughout note 1; note_idx steps 0,1,2; one done pulse.
REQ-037 len=2, loop=1 for two passes, then loop=0 -> note_idx 0,1,0,1, then done; no done between passes.
REQ-038 stop asserted mid-TONE with pin=1 -> next edge pin 0, busy 0, note_idx 0, no done.
REQ-039 rst_n low mid-GAP asynchronously -> outputs clear before the next clk edge; restart replays from index 0.
REQ-040 Corner cases: start with len=0 -> no busy; start+stop in IDLE -> ignored; dur=0 -> 4-cycle TONE.

Source files
------------

// File: rtl/melody_player.sv
// Melody player: plays a table of {half_period, duration} notes as a square wave
// on buzzer_pin, with a silent articulation gap after every note.
module melody_player #(
    parameter int unsigned DEPTH    = 128,
    parameter int unsigned HALF_W   = 20,
    parameter int unsigned DUR_W    = 8,
    parameter int unsigned TICK_CYC = 500000,
    parameter int unsigned GAP_CYC  = 2000000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [$clog2(DEPTH)-1:0]    wr_addr,
    input  logic [HALF_W+DUR_W-1:0]     wr_data,
    input  logic [$clog2(DEPTH):0]      len,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        loop,
    output logic                        buzzer_pin,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(DEPTH)-1:0]    note_idx
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned LW     = AW + 1;
    localparam int unsigned WORD_W = HALF_W + DUR_W;

    // One counter serves both TONE and GAP, so it must hold the longer of the two.
    localparam longint unsigned TONE_MAX = ((64'(1) << DUR_W) - 64'(1)) * 64'(TICK_CYC);
    localparam longint unsigned CNT_MAX  = (TONE_MAX > 64'(GAP_CYC)) ? TONE_MAX : 64'(GAP_CYC);
    localparam int unsigned     CNT_W    = $clog2(CNT_MAX + 64'(1));

    // GAP_CYC = 0 still spends one cycle in GAP.
    localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYC == 0) ? '0 : CNT_W'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        TONE = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       idx_d;
    logic [LW-1:0]       len_q, len_d;
    logic [HALF_W-1:0]   half_q, half_d;
    logic [HALF_W-1:0]   half_cnt_q, half_cnt_d;
    logic [CNT_W-1:0]    tone_last_q, tone_last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pin_d;
    logic                done_d;
    logic                busy_d;

    logic [WORD_W-1:0]   mem [DEPTH];
    logic [WORD_W-1:0]   rd_word;
    logic [AW-1:0]       rd_addr;
    logic [HALF_W-1:0]   rd_half;
    logic [DUR_W-1:0]    rd_dur;
    logic [DUR_W-1:0]    dur_eff;
    logic [CNT_W-1:0]    tone_cyc;
    logic [LW-1:0]       last_idx;

    // Read address tracks the next note index so LOAD sees the word for its own index.
    assign rd_addr  = idx_d;
    assign rd_half  = rd_word[WORD_W-1:DUR_W];
    assign rd_dur   = rd_word[DUR_W-1:0];
    assign dur_eff  = (rd_dur == '0) ? DUR_W'(1) : rd_dur;
    assign tone_cyc = CNT_W'(dur_eff) * CNT_W'(TICK_CYC);
    assign last_idx = len_q - LW'(1);

    // Note memory: synchronous write at any time, synchronous read, no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_word <= mem[rd_addr];
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            note_idx    <= '0;
            len_q       <= '0;
            half_q      <= '0;
            half_cnt_q  <= '0;
            tone_last_q <= '0;
            cnt_q       <= '0;
            buzzer_pin  <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            note_idx    <= idx_d;
            len_q       <= len_d;
            half_q      <= half_d;
            half_cnt_q  <= half_cnt_d;
            tone_last_q <= tone_last_d;
            cnt_q       <= cnt_d;
            buzzer_pin  <= pin_d;
            done        <= done_d;
            busy        <= busy_d;
        end
    end

    // Next-state, counter and output logic.
    always_comb begin
        state_d     = state_q;
        idx_d       = note_idx;
        len_d       = len_q;
        half_d      = half_q;
        half_cnt_d  = half_cnt_q;
        tone_last_d = tone_last_q;
        cnt_d       = cnt_q;
        pin_d       = buzzer_pin;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                pin_d = 1'b0;
                if (start && !stop && (len != '0)) begin
                    state_d = LOAD;
                    len_d   = len;
                    idx_d   = '0;
                end
            end

            LOAD: begin
                half_d      = rd_half;
                tone_last_d = tone_cyc - CNT_W'(1);
                half_cnt_d  = '0;
                cnt_d       = '0;
                pin_d       = 1'b0;
                state_d     = TONE;
            end

            TONE: begin
                if (cnt_q == tone_last_q) begin
                    state_d    = GAP;
                    cnt_d      = '0;
                    half_cnt_d = '0;
                    pin_d      = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (half_q == '0) begin
                        pin_d = 1'b0;
                    end else if (half_cnt_q == (half_q - HALF_W'(1))) begin
                        pin_d      = ~buzzer_pin;
                        half_cnt_d = '0;
                    end else begin
                        half_cnt_d = half_cnt_q + HALF_W'(1);
                    end
                end
            end

            GAP: begin
                pin_d = 1'b0;
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if ({1'b0, note_idx} == last_idx) begin
                        idx_d = '0;
                        if (loop) begin
                            state_d = LOAD;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        idx_d   = note_idx + AW'(1);
                        state_d = LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort takes priority over any normal progression.
        if ((state_q != IDLE) && stop) begin
            state_d    = IDLE;
            pin_d      = 1'b0;
            idx_d      = '0;
            done_d     = 1'b0;
            cnt_d      = '0;
            half_cnt_d = '0;
        end

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_melody_player.sv
// Scoreboard bench for melody_player: a note-level model expands each play
// request into the expected per-cycle output trace; a monitor compares it.
module tb_melody_player;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned AW     = 3;
    localparam int unsigned LW     = AW + 1;
    localparam int unsigned HALF_W = 4;
    localparam int unsigned DUR_W  = 3;
    localparam int unsigned TICK   = 4;
    localparam int unsigned GAP    = 2;

    logic                    clk;
    logic                    rst_n;
    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [HALF_W+DUR_W-1:0] wr_data;
    logic [LW-1:0]           len;
    logic                    start;
    logic                    stop;
    logic                    loop;
    logic                    buzzer_pin;
    logic                    busy;
    logic                    done;
    logic [AW-1:0]           note_idx;

    melody_player #(
        .DEPTH    (DEPTH),
        .HALF_W   (HALF_W),
        .DUR_W    (DUR_W),
        .TICK_CYC (TICK),
        .GAP_CYC  (GAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .len        (len),
        .start      (start),
        .stop       (stop),
        .loop       (loop),
        .buzzer_pin (buzzer_pin),
        .busy       (busy),
        .done       (done),
        .note_idx   (note_idx)
    );

    typedef struct packed {
        logic          pin;
        logic          busy;
        logic          done;
        logic [AW-1:0] idx;
    } obs_t;

    obs_t  exp_q[$];
    obs_t  mon_e;
    obs_t  mon_a;
    int    checks   = 0;
    int    failures = 0;
    int    step     = 0;
    string scen     = "init";

    int unsigned m_half [DEPTH];
    int unsigned m_dur  [DEPTH];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected observation per cycle while the scoreboard holds entries.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {buzzer_pin, busy, done, note_idx};
            checks++;
            if (mon_a !== mon_e) begin
                failures++;
                $display("FAIL trace[%s] step=%0d got pin=%b busy=%b done=%b idx=%0d exp pin=%b busy=%b done=%b idx=%0d",
                         scen, step, mon_a.pin, mon_a.busy, mon_a.done, mon_a.idx,
                         mon_e.pin, mon_e.busy, mon_e.done, mon_e.idx);
            end
            step++;
        end
    end

    function automatic obs_t mk(input int p, input int b, input int d, input int i);
        obs_t o;
        o.pin  = 1'(p);
        o.busy = 1'(b);
        o.done = 1'(d);
        o.idx  = AW'(i);
        return o;
    endfunction

    function automatic int tone_len(input int i);
        return ((m_dur[i] == 0) ? 1 : int'(m_dur[i])) * int'(TICK);
    endfunction

    function automatic int pass_len(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) begin
            s += 1 + tone_len(i) + ((GAP == 0) ? 1 : int'(GAP));
        end
        return s;
    endfunction

    // Model: each note is LOAD, then a tone of max(dur,1) ticks whose pin level is
    // floor(k/H) mod 2 at cycle k, then a silent gap; the sequence ends with done.
    task automatic build_trace(input int n, input int passes, input int stop_at);
        obs_t tr[$];
        int   h;
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < n; i++) begin
                tr.push_back(mk(0, 1, 0, i));
                h = int'(m_half[i]);
                for (int k = 0; k < tone_len(i); k++) begin
                    tr.push_back(mk((h != 0) ? ((k / h) % 2) : 0, 1, 0, i));
                end
                for (int g = 0; g < ((GAP == 0) ? 1 : int'(GAP)); g++) begin
                    tr.push_back(mk(0, 1, 0, i));
                end
            end
        end
        if (stop_at >= 0) begin
            while (tr.size() > stop_at + 1) void'(tr.pop_back());
        end else begin
            tr.push_back(mk(0, 0, 1, 0));
        end
        repeat (3) tr.push_back(mk(0, 0, 0, 0));
        foreach (tr[j]) exp_q.push_back(tr[j]);
    endtask

    task automatic write_note(input int a, input int h, input int d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = {HALF_W'(h), DUR_W'(d)};
        @(posedge clk); #1;
        wr_en = 1'b0;
        m_half[a] = h;
        m_dur[a]  = d;
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, want);
        end
    endtask

    task automatic drain_check(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain[%s] left=%0d exp=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Play n notes for the given passes; optional stop at a cycle and a mid-play write.
    task automatic play(input string name, input int n, input int passes, input int stop_at,
                        input int wr_at, input int wa, input int wh, input int wd);
        int L;
        int c;
        scen = name;
        step = 0;
        if (wr_at >= 0) begin
            m_half[wa] = wh;
            m_dur[wa]  = wd;
        end
        L     = pass_len(n);
        len   = LW'(n);
        loop  = (passes > 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        build_trace(n, passes, stop_at);
        c = 0;
        while (exp_q.size() != 0 && c < passes * L + 20) begin
            start   = (stop_at < 0) && (c == 1);
            stop    = (c == stop_at);
            loop    = (passes > 1) && (c <= (passes - 1) * L);
            wr_en   = (c == wr_at);
            wr_addr = AW'(wa);
            wr_data = {HALF_W'(wh), DUR_W'(wd)};
            @(posedge clk); #1;
            c++;
        end
        start = 1'b0;
        stop  = 1'b0;
        loop  = 1'b0;
        wr_en = 1'b0;
        drain_check(name);
    endtask

    // Requests that must be ignored in IDLE.
    task automatic idle_probe(input string name, input int l, input logic sp);
        int c;
        scen  = name;
        step  = 0;
        len   = LW'(l);
        start = 1'b1;
        stop  = sp;
        @(posedge clk); #1;
        start = 1'b0;
        stop  = 1'b0;
        repeat (3) exp_q.push_back(mk(0, 0, 0, 0));
        c = 0;
        while (exp_q.size() != 0 && c < 10) begin
            @(posedge clk); #1;
            c++;
        end
        drain_check(name);
    endtask

    initial begin
        int n;
        int passes;
        int stop_at;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        len     = '0;
        start   = 1'b0;
        stop    = 1'b0;
        loop    = 1'b0;
        #1;
        chk("reset_pin",  int'(buzzer_pin), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_idx",  int'(note_idx), 0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < int'(DEPTH); i++) write_note(i, 0, 1);

        // Single note {3,2}
        write_note(0, 3, 2);
        play("single", 1, 1, -1, -1, 0, 0, 0);

        // Rest in the middle
        write_note(0, 3, 1);
        write_note(1, 0, 1);
        write_note(2, 2, 2);
        play("rest_mid", 3, 1, -1, -1, 0, 0, 0);

        // Two looped passes then completion
        write_note(0, 1, 1);
        write_note(1, 2, 1);
        play("loop2", 2, 2, -1, -1, 0, 0, 0);

        // Stop while the pin is high (TONE cycle 4 of H=3)
        write_note(0, 3, 2);
        play("stop_hi", 1, 1, 5, -1, 0, 0, 0);

        // dur = 0 behaves as one tick
        write_note(0, 2, 0);
        play("dur0", 1, 1, -1, -1, 0, 0, 0);

        // Write to a not-yet-loaded entry during the first note
        write_note(0, 2, 1);
        write_note(1, 1, 1);
        play("late_wr", 2, 1, -1, 2, 1, 3, 2);

        // Corner requests in IDLE
        idle_probe("len0", 0, 1'b0);
        idle_probe("start_stop", 3, 1'b1);

        // Asynchronous reset in the GAP of note 1, then replay from index 0
        write_note(0, 3, 1);
        write_note(1, 2, 1);
        scen  = "reset_mid";
        len   = LW'(2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("pre_reset_busy", int'(busy), 1);
        chk("pre_reset_idx",  int'(note_idx), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_pin",  int'(buzzer_pin), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_done", int'(done), 0);
        chk("async_idx",  int'(note_idx), 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_busy", int'(busy), 0);
        play("restart", 2, 1, -1, -1, 0, 0, 0);

        // Randomized programs
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                write_note(i, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15)),
                           int'($urandom_range(0, 7)));
            end
            n       = int'($urandom_range(1, DEPTH));
            passes  = int'($urandom_range(1, 2));
            stop_at = -1;
            if (passes == 1 && $urandom_range(0, 3) == 0) begin
                stop_at = int'($urandom_range(0, pass_len(n) - 1));
            end
            play($sformatf("rand%0d", r), n, passes, stop_at, -1, 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
